// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spike window decoder.
// Holds the decoder FSM state enum and default parameter values.
package snn_pkg;

  localparam int N_NEURONS_DEF = 4;
  localparam int CNT_W_DEF     = 8;
  localparam int WIN_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_SCAN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/spike_lane_counter.sv
// Saturating spike counter for one neuron lane.
// Ports: clk, reset (sync, high), clear, en, spike -> count.
module spike_lane_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && spike && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spike_window_decoder.sv
// Counts spikes per lane over a window, then picks the busiest lane.
// Ports: clk, reset, spike_in, window_len, start, busy, out_valid,
//   out_ready, winner, winner_count; tie with
//   SPIKE_WINDOW_DECODER_TIE_FLAG_EN defined.
module spike_window_decoder
  import snn_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int WIN_W     = WIN_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_NEURONS-1:0]         spike_in,
  input  logic [WIN_W-1:0]             window_len,
  input  logic                         start,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_NEURONS)-1:0] winner,
  output logic [CNT_W-1:0]             winner_count
`ifdef SPIKE_WINDOW_DECODER_TIE_FLAG_EN
  ,
  output logic                         tie
`endif
);

  localparam int IDX_W = $clog2(N_NEURONS);

  state_t state;
  state_t state_nxt;

  logic [WIN_W-1:0] remain;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_count;
  logic [CNT_W-1:0] lane_count;
  logic [CNT_W-1:0] counts [N_NEURONS];

  logic accept;
  logic count_en;
  logic last_cnt;
  logic last_scan;
  logic handshake;

  assign accept    = (state == ST_IDLE) && start;
  assign handshake = (state == ST_HOLD) && out_ready;
  assign last_cnt  = (remain == WIN_W'(1));
  assign last_scan = (scan_idx == IDX_W'(N_NEURONS - 1));
  assign lane_count = counts[scan_idx];

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_lane
    spike_lane_counter #(
      .CNT_W(CNT_W)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .clear(accept),
      .en   (count_en),
      .spike(spike_in[g]),
      .count(counts[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start)     state_nxt = ST_COUNT;
      ST_COUNT: if (last_cnt)  state_nxt = ST_SCAN;
      ST_SCAN:  if (last_scan) state_nxt = ST_HOLD;
      ST_HOLD:  if (handshake) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_HOLD);
    count_en  = (state == ST_COUNT);
  end

  // A zero length still opens a one-cycle window.
  always_ff @(posedge clk) begin
    if (reset) begin
      remain     <= '0;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_count <= '0;
    end else if (accept) begin
      remain     <= (window_len == '0) ? WIN_W'(1) : window_len;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_count <= '0;
    end else if (state == ST_COUNT) begin
      remain <= remain - 1'b1;
    end else if (state == ST_SCAN) begin
      if (!last_scan) begin
        scan_idx <= scan_idx + 1'b1;
      end
      // Strictly greater keeps the lowest index on ties.
      if (lane_count > best_count) begin
        best_count <= lane_count;
        best_idx   <= scan_idx;
      end
    end
  end

  assign winner       = best_idx;
  assign winner_count = best_count;

`ifdef SPIKE_WINDOW_DECODER_TIE_FLAG_EN
  logic tie_r;

  // A new leader clears the flag; a nonzero equal sets it.
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      tie_r <= 1'b0;
    end else if (state == ST_SCAN) begin
      if (lane_count > best_count) begin
        tie_r <= 1'b0;
      end else if ((lane_count == best_count) && (best_count != '0)) begin
        tie_r <= 1'b1;
      end
    end
  end

  assign tie = tie_r && out_valid;
`endif

endmodule
